// File: rtl/group_rows_k.sv
`timescale 1ns/1ps
// K-row sign-window generator: turns a raster, channel-interleaved activation stream into
// ternary sign codes and emits KSIZE vertically aligned taps per word, with zero top/bottom padding.
module group_rows_k #(
  parameter int WIDTH_D = 27,
  parameter int SIZE    = 56,
  parameter int CHANNEL = 64,
  parameter int KSIZE   = 3,
  parameter int PADWAIT = 21
) (
  input  logic                      i_sclk,
  input  logic                      i_rst_n,
  input  logic                      i_vsync,
  input  logic                      i_valid,
  input  logic signed [WIDTH_D-1:0] i_tdata,
  output logic                      o_ready,
  output logic                      o_vsync_c,
  output logic                      o_hsync_c,
  output logic                      o_valid_c,
  output logic [2*KSIZE-1:0]        o_tdata_c,
  output logic                      o_ovf
);

  localparam int P       = (KSIZE - 1) / 2;
  localparam int ROW_LEN = SIZE * CHANNEL;
  localparam int NBUF    = KSIZE - 1;
  localparam int COL_W   = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int ROW_W   = $clog2(SIZE + P + 1);
  localparam int WAIT_W  = (PADWAIT > 1) ? $clog2(PADWAIT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(ROW_LEN - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST_IN   = ROW_W'(SIZE - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST_FL   = ROW_W'(SIZE - 1 + P);
  localparam logic [ROW_W-1:0]  ROW_FIRST_OUT = ROW_W'(P);
  localparam logic [WAIT_W-1:0] WAIT_LAST     = WAIT_W'(PADWAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_FLUSH, S_DONE} state_t;

  function automatic logic [1:0] sign_code(input logic signed [WIDTH_D-1:0] v);
    if (~|v) return 2'b00;
    return v[WIDTH_D-1] ? 2'b11 : 2'b01;
  endfunction

  state_t             state, next_state;
  logic               ready_d, flush_wd, accept, drop;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   in_row;
  logic [WAIT_W-1:0]  wait_cnt;

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (i_vsync) begin
      next_state = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (accept && col == COL_LAST && in_row == ROW_LAST_IN)
                   next_state = (P > 0) ? S_GAP : S_DONE;
        S_GAP:   if (wait_cnt == WAIT_LAST) next_state = S_FLUSH;
        S_FLUSH: if (col == COL_LAST) next_state = (in_row == ROW_LAST_FL) ? S_DONE : S_GAP;
        S_DONE:  next_state = S_IDLE;
        default: next_state = state;
      endcase
    end
  end

  always_comb begin
    ready_d  = (next_state == S_IDLE) || (next_state == S_RUN);
    flush_wd = (state == S_FLUSH) && !i_vsync;
    accept   = i_valid && ((state == S_RUN) || i_vsync);
    drop     = i_valid && !accept;
  end

  // ---- stage p0: position of the word entering the window (vsync restarts at col 0, row 0)
  logic               adv_p0;
  logic [COL_W-1:0]   col_p0;
  logic [ROW_W-1:0]   in_row_p0;
  logic [1:0]         code_p0;

  assign adv_p0    = accept || flush_wd;
  assign col_p0    = i_vsync ? '0 : col;
  assign in_row_p0 = i_vsync ? '0 : in_row;
  assign code_p0   = flush_wd ? 2'b00 : sign_code(i_tdata);

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col      <= '0;
      in_row   <= '0;
      wait_cnt <= '0;
      o_ready  <= 1'b0;
      o_ovf    <= 1'b0;
    end else begin
      if (adv_p0 && col_p0 == COL_LAST) begin
        col    <= '0;
        in_row <= in_row_p0 + 1'b1;
      end else begin
        col    <= adv_p0 ? col_p0 + 1'b1 : col_p0;
        in_row <= in_row_p0;
      end
      wait_cnt <= (state == S_GAP && !i_vsync) ? wait_cnt + 1'b1 : '0;
      o_ready  <= ready_d;
      if (drop) o_ovf <= 1'b1;
    end
  end

  // ---- stage p1: synchronous line-buffer read; the row shift is written back one cycle later
  // (read-before-write holds because the same col is revisited only ROW_LEN >= 2 words later)
  logic               vld_p1, we_p1, vsync_p1;
  logic [1:0]         code_p1;
  logic [COL_W-1:0]   col_p1;
  logic [ROW_W-1:0]   in_row_p1;
  logic [1:0]         rd_p1 [NBUF];
  logic [1:0]         mem   [NBUF][ROW_LEN];

  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p1   <= 1'b0;
      we_p1    <= 1'b0;
      vsync_p1 <= 1'b0;
    end else begin
      vld_p1   <= adv_p0 && (in_row_p0 >= ROW_FIRST_OUT);
      we_p1    <= adv_p0;
      vsync_p1 <= i_vsync;
    end
  end

  always_ff @(posedge i_sclk) begin
    code_p1   <= code_p0;
    col_p1    <= col_p0;
    in_row_p1 <= in_row_p0;
    for (int i = 0; i < NBUF; i++) rd_p1[i] <= mem[i][col_p0];
    if (we_p1) begin
      mem[0][col_p1] <= code_p1;
      for (int i = 1; i < NBUF; i++) mem[i][col_p1] <= rd_p1[i-1];
    end
  end

  // Tap j comes from source row in_row-(KSIZE-1)+j; rows outside the frame read as zero,
  // which also hides stale buffer contents after a mid-frame restart.
  logic [1:0]          tap_src [KSIZE];
  logic [2*KSIZE-1:0]  taps_p1;

  always_comb begin : tap_mask
    int src;
    src = 0;
    taps_p1 = '0;
    tap_src[KSIZE-1] = code_p1;
    for (int i = 0; i < NBUF; i++) tap_src[NBUF-1-i] = rd_p1[i];
    for (int j = 0; j < KSIZE; j++) begin
      src = int'(in_row_p1) - (KSIZE - 1) + j;
      if (src >= 0 && src < SIZE) taps_p1[2*j +: 2] = tap_src[j];
    end
  end

  // ---- stage p2: output register
  always_ff @(posedge i_sclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_c <= 1'b0;
      o_hsync_c <= 1'b0;
      o_vsync_c <= 1'b0;
      o_tdata_c <= '0;
    end else begin
      o_valid_c <= vld_p1;
      o_hsync_c <= vld_p1 && (col_p1 == '0);
      o_vsync_c <= vsync_p1;
      if (vld_p1) o_tdata_c <= taps_p1;
    end
  end

endmodule

// File: tb/tb_group_rows_k.sv
`timescale 1ns/1ps
// Scoreboard bench for group_rows_k: two configurations (K=3 and K=5) driven with directed frames.
module tb_group_rows_k;

  localparam int WD = 27;
  localparam int KA = 3, SA = 4, CA = 2, PA = 2;
  localparam int KB = 5, SB = 6, CB = 1, PB = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 vs_in [2];
  logic                 vl_in [2];
  logic signed [WD-1:0] td_in [2];
  logic                 rdy [2], vsc [2], hsc [2], vlc [2], ovf [2];
  logic [2*KA-1:0]      tda;
  logic [2*KB-1:0]      tdb;

  group_rows_k #(.WIDTH_D(WD), .SIZE(SA), .CHANNEL(CA), .KSIZE(KA), .PADWAIT(PA)) dut_a (
    .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vs_in[0]), .i_valid(vl_in[0]), .i_tdata(td_in[0]),
    .o_ready(rdy[0]), .o_vsync_c(vsc[0]), .o_hsync_c(hsc[0]), .o_valid_c(vlc[0]),
    .o_tdata_c(tda), .o_ovf(ovf[0]));

  group_rows_k #(.WIDTH_D(WD), .SIZE(SB), .CHANNEL(CB), .KSIZE(KB), .PADWAIT(PB)) dut_b (
    .i_sclk(clk), .i_rst_n(rst_n), .i_vsync(vs_in[1]), .i_valid(vl_in[1]), .i_tdata(td_in[1]),
    .o_ready(rdy[1]), .o_vsync_c(vsc[1]), .o_hsync_c(hsc[1]), .o_valid_c(vlc[1]),
    .o_tdata_c(tdb), .o_ovf(ovf[1]));

  typedef struct {
    logic [9:0] td;
    logic       hs;
    int         due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   frm [2][8][8];
  int   mrow [2], mcol [2], vs_due [2], nvld [2], nhs [2], npush [2];
  int   n_cmp = 0, n_bad = 0;
  bit   use_hand = 0;
  logic [9:0] hand_row [4];

  function automatic int kof(int u);  return (u == 0) ? KA : KB; endfunction
  function automatic int sof(int u);  return (u == 0) ? SA : SB; endfunction
  function automatic int rlof(int u); return (u == 0) ? SA*CA : SB*CB; endfunction
  function automatic int pof(int u);  return (kof(u) - 1) / 2; endfunction

  function automatic logic [1:0] code(int v);
    if (v > 0) return 2'b01;
    if (v < 0) return 2'b11;
    return 2'b00;
  endfunction

  // Golden padded window: tap j sees source row r_in-(K-1)+j, zero outside the frame.
  function automatic logic [9:0] exp_word(int u, int r_in, int c);
    logic [9:0] w;
    int s;
    w = '0;
    for (int j = 0; j < kof(u); j++) begin
      s = r_in - (kof(u) - 1) + j;
      if (s >= 0 && s < sof(u)) w[2*j +: 2] = code(frm[u][s][c]);
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(int u, int r_in, int c, int due);
    exp_t e;
    e.td  = use_hand ? hand_row[r_in - pof(u)] : exp_word(u, r_in, c);
    e.hs  = (c == 0);
    e.due = due;
    if (u == 0) qa.push_back(e); else qb.push_back(e);
    npush[u]++;
  endtask

  function automatic int qsize(int u);
    return (u == 0) ? qa.size() : qb.size();
  endfunction

  function automatic exp_t qpop(int u);
    if (u == 0) return qa.pop_front();
    return qb.pop_front();
  endfunction

  task automatic idle(int u, int n);
    repeat (n) begin
      @(negedge clk);
      vs_in[u] = 1'b0;
      vl_in[u] = 1'b0;
    end
  endtask

  task automatic vsync_only(int u);
    @(negedge clk);
    vs_in[u] = 1'b1;
    vl_in[u] = 1'b0;
    mrow[u] = 0; mcol[u] = 0;
    vs_due[u] = cyc + 2;
  endtask

  task automatic send(int u, int v, bit vs);
    @(negedge clk);
    vs_in[u] = vs;
    vl_in[u] = 1'b1;
    td_in[u] = WD'(v);
    if (vs) begin
      mrow[u] = 0; mcol[u] = 0;
      vs_due[u] = cyc + 2;
    end
    frm[u][mrow[u]][mcol[u]] = v;
    if (mrow[u] >= pof(u)) push(u, mrow[u], mcol[u], cyc + 2);
    mcol[u]++;
    if (mcol[u] == rlof(u)) begin
      mcol[u] = 0;
      mrow[u]++;
    end
  endtask

  task automatic push_flush(int u);
    for (int r = sof(u); r < sof(u) + pof(u); r++)
      for (int c = 0; c < rlof(u); c++) push(u, r, c, -1);
  endtask

  task automatic clear_counts(int u);
    nvld[u] = 0; nhs[u] = 0; npush[u] = 0;
  endtask

  // Frame used by the K=3 directed cases: rows +5, -3, 0, +1.
  task automatic frame_a(bit gaps);
    int vals [4];
    vals = '{5, -3, 0, 1};
    vsync_only(0);
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SA*CA; c++) begin
        if (gaps) while ($urandom_range(0, 9) >= 3) idle(0, 1);
        send(0, vals[r], 1'b0);
      end
    push_flush(0);
  endtask

  // ---- monitor
  always @(negedge clk) begin : monitor
    logic [9:0] td_now;
    exp_t e;
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        td_now = (u == 0) ? {4'b0, tda} : tdb;
        if (hsc[u] && !vlc[u]) chk($sformatf("u%0d hsync_without_valid", u), 64'(hsc[u]), 64'(0));
        if (vlc[u]) begin
          nvld[u]++;
          if (hsc[u]) nhs[u]++;
          if (qsize(u) == 0) begin
            chk($sformatf("u%0d unexpected_word", u), 64'(1), 64'(0));
          end else begin
            e = qpop(u);
            chk($sformatf("u%0d tdata", u), 64'(td_now), 64'(e.td));
            chk($sformatf("u%0d hsync", u), 64'(hsc[u]), 64'(e.hs));
            if (e.due >= 0) chk($sformatf("u%0d latency_cycle", u), 64'(cyc), 64'(e.due));
          end
        end
        if (vsc[u] || cyc == vs_due[u])
          chk($sformatf("u%0d vsync_c", u), 64'(vsc[u]), 64'(cyc == vs_due[u]));
      end
    end
  end

  task automatic check_frame(int u, int words, int rows, string tag);
    chk({tag, " valid_count"}, 64'(nvld[u]), 64'(words));
    chk({tag, " hsync_count"}, 64'(nhs[u]), 64'(rows));
    chk({tag, " queue_drained"}, 64'(qsize(u)), 64'(0));
  endtask

  initial begin : stim
    int low;
    bit seen_hi;
    for (int u = 0; u < 2; u++) begin
      vs_in[u] = 0; vl_in[u] = 0; td_in[u] = '0;
      mrow[u] = 0; mcol[u] = 0; vs_due[u] = -100;
      clear_counts(u);
    end
    // Hand-derived rows {code(r+1), code(r), code(r-1)} for rows +5,-3,0,+1
    hand_row[0] = 10'b00_0011_0100;
    hand_row[1] = 10'b00_0000_1101;
    hand_row[2] = 10'b00_0001_0011;
    hand_row[3] = 10'b00_0000_0100;

    // Reset state
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d reset o_ready", u), 64'(rdy[u]), 64'(0));
      chk($sformatf("u%0d reset o_valid_c", u), 64'(vlc[u]), 64'(0));
      chk($sformatf("u%0d reset o_hsync_c", u), 64'(hsc[u]), 64'(0));
      chk($sformatf("u%0d reset o_vsync_c", u), 64'(vsc[u]), 64'(0));
      chk($sformatf("u%0d reset o_ovf", u), 64'(ovf[u]), 64'(0));
    end
    chk("u0 reset o_tdata_c", 64'(tda), 64'(0));
    chk("u1 reset o_tdata_c", 64'(tdb), 64'(0));
    rst_n = 1'b1;
    idle(0, 2);
    chk("u0 idle o_ready", 64'(rdy[0]), 64'(1));
    chk("u1 idle o_ready", 64'(rdy[1]), 64'(1));

    // Test 1: K=3 continuous frame, hand-computed rows
    use_hand = 1;
    clear_counts(0);
    frame_a(1'b0);

    // Test 2: flush window length, dropped word in FLUSH
    low = 0; seen_hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vs_in[0] = 1'b0;
      vl_in[0] = (i == 5);
      td_in[0] = WD'(7);
      if (!seen_hi) begin
        if (rdy[0] == 1'b0) low++;
        else seen_hi = 1;
      end
    end
    chk("t2 ready_low_cycles", 64'(low), 64'(PA + SA*CA + 1));
    chk("t2 ovf_after_drop", 64'(ovf[0]), 64'(1));
    check_frame(0, SA*SA*CA, SA, "t1");

    // Test 3: K=5, random signed data against the padded window model
    use_hand = 0;
    clear_counts(1);
    vsync_only(1);
    for (int r = 0; r < SB; r++)
      for (int c = 0; c < SB*CB; c++) send(1, int'($urandom_range(0, 4)) - 2, 1'b0);
    push_flush(1);
    idle(1, 45);
    check_frame(1, SB*SB*CB, SB, "t3");
    chk("t3 ovf_clear", 64'(ovf[1]), 64'(0));

    // Test 4: mid-row restart, then a frame of all -1 (vsync with first word)
    clear_counts(0);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < ((r == 2) ? 4 : SA*CA); c++)
        send(0, (r == 0) ? 2 : (r == 1) ? -4 : 3, (r == 0 && c == 0));
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SA*CA; c++) send(0, -1, (r == 0 && c == 0));
    push_flush(0);
    idle(0, 25);
    chk("t4 valid_count", 64'(nvld[0]), 64'(npush[0]));
    chk("t4 hsync_count", 64'(nhs[0]), 64'(2 + SA));
    chk("t4 queue_drained", 64'(qsize(0)), 64'(0));

    // Test 5: 30% input duty, same frame as test 1
    use_hand = 1;
    clear_counts(0);
    frame_a(1'b1);
    idle(0, 25);
    check_frame(0, SA*SA*CA, SA, "t5");

    // Test 6: async reset during FLUSH, then a clean frame
    frame_a(1'b0);
    idle(0, 4);
    chk("t6 ovf_before_reset", 64'(ovf[0]), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6 async o_ready", 64'(rdy[0]), 64'(0));
    chk("t6 async o_valid_c", 64'(vlc[0]), 64'(0));
    chk("t6 async o_hsync_c", 64'(hsc[0]), 64'(0));
    chk("t6 async o_vsync_c", 64'(vsc[0]), 64'(0));
    chk("t6 async o_tdata_c", 64'(tda), 64'(0));
    chk("t6 async o_ovf", 64'(ovf[0]), 64'(0));
    qa.delete();
    vs_due[0] = -100;
    @(negedge clk);
    rst_n = 1'b1;
    idle(0, 2);
    chk("t6 idle o_ready", 64'(rdy[0]), 64'(1));
    clear_counts(0);
    frame_a(1'b0);
    idle(0, 25);
    check_frame(0, SA*SA*CA, SA, "t6");
    chk("t6 ovf_stays_clear", 64'(ovf[0]), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
